// File: rtl/ramio_arbiter_pkg.sv
// ramio_arbiter_pkg: shared types for the RAMIO command-port arbiter.
// Imported by the arbiter top and its helpers.
package ramio_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ACTIVE,
    RELEASE
  } state_t;

  typedef struct packed {
    logic [1:0]  write_type;
    logic [2:0]  read_type;
    logic [31:0] address;
    logic [31:0] data_in;
  } ramio_cmd_t;

  localparam int TIMEOUT_BITWIDTH_DEF = 16;
  localparam logic [TIMEOUT_BITWIDTH_DEF-1:0] TIMEOUT_MAX = '1;

endpackage

// File: rtl/rr_picker.sv
// rr_picker: combinational round-robin selector.
// Takes a one-hot priority pointer; returns a one-hot grant.
module rr_picker #(
  parameter int NUM_REQ = 2
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [NUM_REQ-1:0] rr_ptr,
  output logic [NUM_REQ-1:0] grant,
  output logic               valid
);

  // Scan upward from the pointer position, wrapping.
  always_comb begin
    grant = '0;
    valid = 1'b0;
    for (int s = 0; s < NUM_REQ; s++) begin
      for (int k = 0; k < NUM_REQ; k++) begin
        if (rr_ptr[s] && !valid && req[(s + k) % NUM_REQ]) begin
          grant[(s + k) % NUM_REQ] = 1'b1;
          valid = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/ramio_arbiter.sv
// ramio_arbiter: round-robin share of one RAMIO command port.
// Grant held for a full transaction, guarded by a watchdog.
module ramio_arbiter
  import ramio_arbiter_pkg::*;
#(
  parameter int NUM_REQ          = 2,
  parameter int TIMEOUT_BITWIDTH = TIMEOUT_BITWIDTH_DEF
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NUM_REQ-1:0]      req_enable,
  input  logic [NUM_REQ*2-1:0]    req_write_type,
  input  logic [NUM_REQ*3-1:0]    req_read_type,
  input  logic [NUM_REQ*32-1:0]   req_address,
  input  logic [NUM_REQ*32-1:0]   req_data_in,
  output logic [31:0]             req_data_out,
  output logic [NUM_REQ-1:0]      req_done,
  output logic [NUM_REQ-1:0]      req_grant,
  output logic                    ramio_enable,
  output logic [1:0]              ramio_write_type,
  output logic [2:0]              ramio_read_type,
  output logic [31:0]             ramio_address,
  output logic [31:0]             ramio_data_in,
  input  logic [31:0]             ramio_data_out,
  input  logic                    ramio_data_out_ready,
  input  logic                    ramio_busy,
  output logic                    timeout_error
);

  state_t                      state, state_n;
  ramio_cmd_t                  cmd_q, sel_cmd;
  logic [NUM_REQ-1:0]          pick, grant_q, done_q, rr_q;
  logic                        pick_v, en_q, terr_q;
  logic [31:0]                 dout_q;
  logic [TIMEOUT_BITWIDTH-1:0] wd, wd_inc;
  logic                        is_read, start;
  logic                        complete, expire;

  rr_picker #(.NUM_REQ(NUM_REQ)) u_pick (
    .req    (req_enable),
    .rr_ptr (rr_q),
    .grant  (pick),
    .valid  (pick_v)
  );

  always_comb begin
    sel_cmd = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (pick[i]) begin
        sel_cmd.write_type = req_write_type[i*2 +: 2];
        sel_cmd.read_type  = req_read_type[i*3 +: 3];
        sel_cmd.address    = req_address[i*32 +: 32];
        sel_cmd.data_in    = req_data_in[i*32 +: 32];
      end
    end
  end

  // wd==0 marks the first ACTIVE cycle, where completion is ignored.
  assign wd_inc   = wd + TIMEOUT_BITWIDTH'(1);
  assign is_read  = (cmd_q.write_type == 2'b00);
  assign start    = (state == IDLE) && !ramio_busy && pick_v;
  assign complete = (state == ACTIVE) && (wd != '0) &&
                    (is_read ? ramio_data_out_ready : !ramio_busy);
  assign expire   = (state == ACTIVE) && !complete && (&wd_inc);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  always_comb begin
    state_n = state;
    unique case (state)
      IDLE:    if (start) state_n = ACTIVE;
      ACTIVE:  if (complete || expire) state_n = RELEASE;
      RELEASE: state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      grant_q <= '0;
      done_q  <= '0;
      rr_q    <= NUM_REQ'(1);
      en_q    <= 1'b0;
      cmd_q   <= '0;
      dout_q  <= '0;
      wd      <= '0;
      terr_q  <= 1'b0;
    end else begin
      done_q <= '0;
      unique case (state)
        IDLE: begin
          if (start) begin
            grant_q <= pick;
            en_q    <= 1'b1;
            cmd_q   <= sel_cmd;
            wd      <= '0;
          end
        end
        ACTIVE: begin
          wd <= wd_inc;
          if (complete || expire) begin
            done_q <= grant_q;
            en_q   <= 1'b0;
          end
          if (complete && is_read) dout_q <= ramio_data_out;
          if (expire) terr_q <= 1'b1;
        end
        RELEASE: begin
          grant_q <= '0;
          rr_q    <= {grant_q[NUM_REQ-2:0], grant_q[NUM_REQ-1]};
        end
        default: ;
      endcase
    end
  end

  assign req_grant        = grant_q;
  assign req_done         = done_q;
  assign req_data_out     = dout_q;
  assign ramio_enable     = en_q;
  assign ramio_write_type = cmd_q.write_type;
  assign ramio_read_type  = cmd_q.read_type;
  assign ramio_address    = cmd_q.address;
  assign ramio_data_in    = cmd_q.data_in;
  assign timeout_error    = terr_q;

endmodule

// File: tb/tb_ramio_arbiter.sv
// tb_ramio_arbiter: directed and randomized checks of ramio_arbiter
// against a RAMIO responder and a round-robin reference model.
module tb_ramio_arbiter;

  localparam int N  = 3;
  localparam int TW = 4;

  logic            clk = 1'b0;
  logic            rst;
  logic [N-1:0]    req_enable;
  logic [N*2-1:0]  req_write_type;
  logic [N*3-1:0]  req_read_type;
  logic [N*32-1:0] req_address;
  logic [N*32-1:0] req_data_in;
  logic [31:0]     req_data_out;
  logic [N-1:0]    req_done;
  logic [N-1:0]    req_grant;
  logic            ramio_enable;
  logic [1:0]      ramio_write_type;
  logic [2:0]      ramio_read_type;
  logic [31:0]     ramio_address;
  logic [31:0]     ramio_data_in;
  logic [31:0]     ramio_data_out = '0;
  logic            ramio_data_out_ready = 1'b0;
  logic            ramio_busy;
  logic            timeout_error;

  logic [1:0]  cw [N];
  logic [2:0]  cr [N];
  logic [31:0] ca [N];
  logic [31:0] cd [N];

  int          lat = 2;
  bit          hang = 1'b0;
  bit          force_busy = 1'b0;
  logic [31:0] rdata = '0;
  logic        busy_m = 1'b0;
  bit          serving = 1'b0;
  int          rcnt = 0;

  int          total = 0;
  int          bad = 0;
  logic [31:0] exp_dout = '0;

  always #5 clk = ~clk;

  always_comb begin
    for (int i = 0; i < N; i++) begin
      req_write_type[i*2 +: 2] = cw[i];
      req_read_type[i*3 +: 3]  = cr[i];
      req_address[i*32 +: 32]  = ca[i];
      req_data_in[i*32 +: 32]  = cd[i];
    end
  end

  assign ramio_busy = busy_m | force_busy;

  ramio_arbiter #(.NUM_REQ(N), .TIMEOUT_BITWIDTH(TW)) dut (
    .clk                  (clk),
    .rst                  (rst),
    .req_enable           (req_enable),
    .req_write_type       (req_write_type),
    .req_read_type        (req_read_type),
    .req_address          (req_address),
    .req_data_in          (req_data_in),
    .req_data_out         (req_data_out),
    .req_done             (req_done),
    .req_grant            (req_grant),
    .ramio_enable         (ramio_enable),
    .ramio_write_type     (ramio_write_type),
    .ramio_read_type      (ramio_read_type),
    .ramio_address        (ramio_address),
    .ramio_data_in        (ramio_data_in),
    .ramio_data_out       (ramio_data_out),
    .ramio_data_out_ready (ramio_data_out_ready),
    .ramio_busy           (ramio_busy),
    .timeout_error        (timeout_error)
  );

  // RAMIO responder: busy from the cycle after enable, finishes after lat cycles.
  always begin
    @(posedge clk);
    #1;
    ramio_data_out_ready = 1'b0;
    ramio_data_out = $urandom;
    if (rst || !ramio_enable) begin
      serving = 1'b0;
      busy_m  = 1'b0;
    end else if (!serving) begin
      serving = 1'b1;
      rcnt    = 0;
      busy_m  = 1'b1;
    end else begin
      rcnt++;
      if (!hang && rcnt >= lat) begin
        busy_m = 1'b0;
        if (ramio_write_type == 2'b00) begin
          ramio_data_out_ready = 1'b1;
          ramio_data_out = rdata;
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL global_timeout bad=%0d", bad);
    $fatal(1, "simulation time limit");
  end

  function automatic int rr_pick(input logic [N-1:0] m, input int p);
    int r;
    r = -1;
    for (int k = N - 1; k >= 0; k--)
      if (m[(p + k) % N]) r = (p + k) % N;
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic wait_grant(output int n);
    n = -1;
    for (int k = 1; k <= 40; k++) begin
      tick();
      if (req_grant != '0) begin
        n = k;
        break;
      end
    end
  endtask

  task automatic wait_done(output int n);
    n = -1;
    for (int k = 1; k <= 40; k++) begin
      tick();
      if (req_done != '0) begin
        n = k;
        break;
      end
    end
  endtask

  task automatic set_read(input int i);
    cw[i] = 2'b00;
    cr[i] = 3'($urandom);
    ca[i] = $urandom;
    cd[i] = $urandom;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    req_enable = '0;
    for (int i = 0; i < N; i++) set_read(i);
    repeat (3) tick();
    total++;
    if ({req_grant, req_done, ramio_enable, ramio_write_type, ramio_read_type,
         ramio_address, ramio_data_in} !== '0) begin
      bad++;
      $display("FAIL reset_outputs got=%h want=0", {req_grant, req_done,
        ramio_enable, ramio_write_type, ramio_read_type, ramio_address, ramio_data_in});
    end
    total++;
    if ({req_data_out, timeout_error} !== '0) begin
      bad++;
      $display("FAIL reset_status got=%h want=0", {req_data_out, timeout_error});
    end
    rst = 1'b0;
    exp_dout = '0;
  endtask

  task automatic test_single_read();
    int n;
    cw[0] = 2'b00; cr[0] = 3'b111; ca[0] = 32'h0000_0010;
    lat = 3; rdata = 32'hDEAD_BEEF;
    req_enable = 3'b001;
    wait_grant(n);
    total++;
    if (n !== 1) begin bad++; $display("FAIL read_grant_wait got=%0d want=1", n); end
    total++;
    if (req_grant !== 3'b001) begin
      bad++; $display("FAIL read_grant got=%b want=001", req_grant);
    end
    total++;
    if ({ramio_enable, ramio_write_type, ramio_read_type, ramio_address} !==
        {1'b1, 2'b00, 3'b111, 32'h10}) begin
      bad++;
      $display("FAIL read_cmd got=%h want=%h",
        {ramio_enable, ramio_write_type, ramio_read_type, ramio_address},
        {1'b1, 2'b00, 3'b111, 32'h10});
    end
    wait_done(n);
    total++;
    if (n !== 4) begin bad++; $display("FAIL read_latency got=%0d want=4", n); end
    total++;
    if ({req_done, req_data_out, ramio_enable} !== {3'b001, 32'hDEAD_BEEF, 1'b0}) begin
      bad++;
      $display("FAIL read_done got=%b/%h/%b want=001/deadbeef/0",
        req_done, req_data_out, ramio_enable);
    end
    exp_dout = 32'hDEAD_BEEF;
    req_enable = '0;
    tick();
    total++;
    if ({req_done, req_grant} !== '0) begin
      bad++; $display("FAIL read_release got=%b want=0", {req_done, req_grant});
    end
  endtask

  task automatic test_simultaneous();
    int n, e;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    set_read(0); set_read(1);
    req_enable = 3'b011;
    for (int t = 0; t < 4; t++) begin
      e = t % 2;
      lat = $urandom_range(1, 4);
      rdata = $urandom;
      wait_grant(n);
      total++;
      if (n !== ((t == 0) ? 1 : 2)) begin
        bad++; $display("FAIL rr_wait t=%0d got=%0d", t, n);
      end
      total++;
      if (req_grant !== (N'(1) << e) || ramio_address !== ca[e]) begin
        bad++;
        $display("FAIL rr_order t=%0d got=%b/%h want=%0d/%h",
          t, req_grant, ramio_address, e, ca[e]);
      end
      wait_done(n);
      total++;
      if (n !== lat + 1 || req_done !== (N'(1) << e) || req_data_out !== rdata) begin
        bad++;
        $display("FAIL rr_done t=%0d got=%0d/%b/%h want=%0d/%0d/%h",
          t, n, req_done, req_data_out, lat + 1, e, rdata);
      end
      exp_dout = rdata;
      set_read(e);
    end
    req_enable = '0;
    tick();
  endtask

  task automatic test_write();
    int n;
    cw[1] = 2'b11; ca[1] = 32'h100; cd[1] = 32'h1234_5678;
    lat = 5;
    req_enable = 3'b010;
    wait_grant(n);
    total++;
    if (n !== 1 || req_grant !== 3'b010) begin
      bad++; $display("FAIL wr_grant got=%0d/%b want=1/010", n, req_grant);
    end
    n = -1;
    for (int k = 1; k <= 40; k++) begin
      total++;
      if (ramio_data_in !== 32'h1234_5678 || ramio_write_type !== 2'b11) begin
        bad++;
        $display("FAIL wr_hold k=%0d got=%h/%b", k, ramio_data_in, ramio_write_type);
      end
      tick();
      if (req_done != '0) begin
        n = k;
        break;
      end
    end
    total++;
    if (n !== 6 || req_done !== 3'b010) begin
      bad++; $display("FAIL wr_done got=%0d/%b want=6/010", n, req_done);
    end
    total++;
    if (req_data_out !== exp_dout) begin
      bad++; $display("FAIL wr_dout got=%h want=%h", req_data_out, exp_dout);
    end
    req_enable = '0;
    tick();
  endtask

  task automatic test_busy_block();
    int n;
    set_read(0);
    lat = 2; rdata = $urandom;
    force_busy = 1'b1;
    req_enable = 3'b001;
    for (int k = 0; k < 10; k++) begin
      tick();
      total++;
      if (req_grant !== '0 || ramio_enable !== 1'b0) begin
        bad++;
        $display("FAIL busy_hold k=%0d got=%b/%b want=0/0", k, req_grant, ramio_enable);
      end
    end
    force_busy = 1'b0;
    wait_grant(n);
    total++;
    if (n !== 1 || req_grant !== 3'b001) begin
      bad++; $display("FAIL busy_grant got=%0d/%b want=1/001", n, req_grant);
    end
    wait_done(n);
    total++;
    if (n !== 3 || req_data_out !== rdata) begin
      bad++; $display("FAIL busy_done got=%0d/%h want=3/%h", n, req_data_out, rdata);
    end
    exp_dout = rdata;
    req_enable = '0;
    tick();
  endtask

  task automatic test_timeout();
    int n;
    set_read(2);
    hang = 1'b1;
    req_enable = 3'b100;
    wait_grant(n);
    total++;
    if (n !== 1 || req_grant !== 3'b100) begin
      bad++; $display("FAIL to_grant got=%0d/%b want=1/100", n, req_grant);
    end
    wait_done(n);
    total++;
    if (n !== 15 || req_done !== 3'b100) begin
      bad++; $display("FAIL to_done got=%0d/%b want=15/100", n, req_done);
    end
    total++;
    if ({timeout_error, ramio_enable, req_data_out} !== {1'b1, 1'b0, exp_dout}) begin
      bad++;
      $display("FAIL to_status got=%b/%b/%h want=1/0/%h",
        timeout_error, ramio_enable, req_data_out, exp_dout);
    end
    hang = 1'b0;
    req_enable = '0;
    tick();
    set_read(0);
    lat = 2; rdata = $urandom;
    req_enable = 3'b001;
    wait_grant(n);
    total++;
    if (req_grant !== 3'b001) begin
      bad++; $display("FAIL to_next_grant got=%b want=001", req_grant);
    end
    wait_done(n);
    total++;
    if (n !== 3 || req_data_out !== rdata || timeout_error !== 1'b1) begin
      bad++;
      $display("FAIL to_sticky got=%0d/%h/%b want=3/%h/1",
        n, req_data_out, timeout_error, rdata);
    end
    exp_dout = rdata;
    req_enable = '0;
    repeat (3) tick();
    total++;
    if (timeout_error !== 1'b1) begin
      bad++; $display("FAIL to_sticky_idle got=%b want=1", timeout_error);
    end
  endtask

  task automatic test_reset_mid();
    int n;
    set_read(1);
    lat = 6; rdata = $urandom;
    req_enable = 3'b010;
    wait_grant(n);
    total++;
    if (req_grant !== 3'b010) begin
      bad++; $display("FAIL rm_grant got=%b want=010", req_grant);
    end
    tick();
    tick();
    #1 rst = 1'b1;
    #1;
    total++;
    if ({ramio_enable, req_grant, timeout_error, req_done, req_data_out} !== '0) begin
      bad++;
      $display("FAIL rm_async got=%b/%b/%b/%b/%h want=0",
        ramio_enable, req_grant, timeout_error, req_done, req_data_out);
    end
    tick();
    rst = 1'b0;
    set_read(0); set_read(1); set_read(2);
    lat = 2; rdata = $urandom;
    req_enable = 3'b111;
    wait_grant(n);
    total++;
    if (n !== 1 || req_grant !== 3'b001) begin
      bad++; $display("FAIL rm_regrant got=%0d/%b want=1/001", n, req_grant);
    end
    wait_done(n);
    total++;
    if (n !== 3 || req_data_out !== rdata) begin
      bad++; $display("FAIL rm_done got=%0d/%h want=3/%h", n, req_data_out, rdata);
    end
    req_enable = '0;
    tick();
  endtask

  task automatic test_random();
    int n, g, ptr;
    logic [N-1:0] mask;
    logic [68:0]  held;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    ptr = 0;
    exp_dout = '0;
    for (int t = 0; t < 40; t++) begin
      mask = N'($urandom_range(1, (1 << N) - 1));
      for (int i = 0; i < N; i++) begin
        set_read(i);
        if ($urandom_range(0, 1) == 1) cw[i] = 2'($urandom_range(1, 3));
      end
      lat = $urandom_range(1, 6);
      rdata = $urandom;
      req_enable = mask;
      g = rr_pick(mask, ptr);
      held = {cw[g], cr[g], ca[g], cd[g]};
      wait_grant(n);
      total++;
      if (n !== 1 || req_grant !== (N'(1) << g)) begin
        bad++;
        $display("FAIL rand_grant t=%0d got=%0d/%b want=1/%0d", t, n, req_grant, g);
      end
      total++;
      if ({ramio_write_type, ramio_read_type, ramio_address, ramio_data_in} !== held) begin
        bad++;
        $display("FAIL rand_cmd t=%0d got=%h want=%h", t,
          {ramio_write_type, ramio_read_type, ramio_address, ramio_data_in}, held);
      end
      for (int i = 0; i < N; i++) begin
        cr[i] = 3'($urandom);
        ca[i] = $urandom;
        cd[i] = $urandom;
      end
      req_enable = N'($urandom);
      wait_done(n);
      if (held[68:67] == 2'b00) exp_dout = rdata;
      total++;
      if (n !== lat + 1 || req_done !== (N'(1) << g) || req_data_out !== exp_dout) begin
        bad++;
        $display("FAIL rand_done t=%0d got=%0d/%b/%h want=%0d/%0d/%h",
          t, n, req_done, req_data_out, lat + 1, g, exp_dout);
      end
      total++;
      if ({ramio_write_type, ramio_read_type, ramio_address, ramio_data_in} !== held) begin
        bad++; $display("FAIL rand_hold t=%0d", t);
      end
      ptr = (g + 1) % N;
      req_enable = N'($urandom);
      tick();
      total++;
      if (req_grant !== '0 || req_done !== '0) begin
        bad++; $display("FAIL rand_release t=%0d got=%b/%b", t, req_grant, req_done);
      end
    end
    total++;
    if (timeout_error !== 1'b0) begin
      bad++; $display("FAIL rand_no_timeout got=%b want=0", timeout_error);
    end
    req_enable = '0;
    tick();
  endtask

  initial begin
    test_reset();
    test_single_read();
    test_simultaneous();
    test_write();
    test_busy_block();
    test_timeout();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
